load_store_unit: RTL and testbench

Initiator end of the data-memory request/response protocol: converts one pipeline load/store op into a single memory transaction. Drives the data port (addr, wdata, byte enables, read/write enables, valid), waits for ready and, for loads, rdata_valid. Returns aligned, sign/zero-extended load data to the pipeline. One transaction outstanding at a time; sits between the execute stage and the data memory controller.

---
 rtl/load_store_unit_pkg.sv | 74 +++++++
 rtl/load_store_unit_load_align.sv | 49 ++++
 rtl/load_store_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit: RV32 funct3 width/sign codes,
// FSM state encoding and small helpers for byte-lane generation.
//
// Contents:
//   F3_*            funct3 codes for loads and stores
//   lsu_state_t     FSM states IDLE / REQ / WAIT_RD / RESP
//   lane_byte_en()  byte enables for a width code and address low bits
//   lane_wdata()    store data replicated across all lanes of its width
//   is_misaligned() natural-alignment check (used only when
//                   LSU_MISALIGN_TRAP_EN is defined)
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    // Load codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] carries the access width
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_t;

    // Half accesses only look at addr[1] and word accesses always use lane 0,
    // so misaligned low bits are truncated to the natural alignment here.
    function automatic logic [3:0] lane_byte_en(input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
        logic [31:0] wd;
        case (funct3[1:0])
            SZ_BYTE: wd = {4{wdata[7:0]}};
            SZ_HALF: wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data alignment: picks the addressed byte/half lane out of
// the returned memory word and sign- or zero-extends it to 32 bits.
//
// Ports:
//   i_funct3   load funct3 (LB/LH/LW/LBU/LHU)
//   i_addr_lo  captured byte address bits [1:0]
//   i_word     raw 32-bit word from memory
//   o_data     extended result
// -----------------------------------------------------------------------------
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = 32'h0;

        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase

        // addr[0] is ignored for halves: misaligned halves fold onto the
        // naturally aligned lane.
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'h0, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator end of the data-memory request/response protocol. Takes one load
// or store from the execute stage, issues a single memory transaction, and
// returns aligned/extended load data with a one-cycle done pulse. Only one
// transaction is ever outstanding.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word ops issue no request and complete with
//               lsu_err_out on the next cycle.
//   undefined - low address bits are truncated to the natural alignment and
//               the access proceeds; lsu_err_out reports timeouts only.
//
// Handshake: a request is presented while data_valid_out is high and all
// request fields are held stable until the cycle data_ready_in is also high;
// that cycle completes the request phase. For loads, the data phase completes
// in the first cycle data_rdata_valid_in is high while waiting (this may be
// the request-acceptance cycle itself).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   lsu_*_in                 pipeline op (valid, load/store, funct3, addr,
//                            wdata, rd)
//   lsu_ready_out            high only in IDLE
//   lsu_done_out/err_out     one-cycle completion / error pulse
//   lsu_rdata_out/rd_out     extended load data / echoed rd, valid with done
//   data_*_out               memory request (word address, lane data, byte
//                            enables, read/write enables, valid)
//   data_ready_in            responder accepts request
//   data_rdata_valid_in/_in  read response
//   dbg_state_out            current FSM state
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        lsu_valid_in,
    input  logic        lsu_is_load_in,
    input  logic        lsu_is_store_in,
    input  logic [2:0]  lsu_funct3_in,
    input  logic [31:0] lsu_addr_in,
    input  logic [31:0] lsu_wdata_in,
    input  logic [4:0]  lsu_rd_in,
    output logic        lsu_ready_out,
    output logic        lsu_done_out,
    output logic [31:0] lsu_rdata_out,
    output logic [4:0]  lsu_rd_out,
    output logic        lsu_err_out,

    output logic [31:0] data_addr_out,
    output logic [31:0] data_wdata_out,
    output logic [3:0]  data_byte_en_out,
    output logic        data_read_en_out,
    output logic        data_write_en_out,
    output logic        data_valid_out,
    input  logic        data_ready_in,
    input  logic        data_rdata_valid_in,
    input  logic [31:0] data_rdata_in,

    output lsu_state_t  dbg_state_out
);

    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
    // The counter is compared before it increments, so the last waiting
    // cycle is the one where it still reads TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       r_state;
    lsu_state_t       w_state_next;

    logic             r_is_load;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [4:0]       r_rd;
    logic             r_err;
    logic [31:0]      r_rdata_word;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_misaligned;
    logic             w_capture;
    logic             w_timeout;
    logic [31:0]      w_load_data;

    assign w_accept = lsu_valid_in && (r_state == ST_IDLE) &&
                      (lsu_is_load_in || lsu_is_store_in);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misaligned = is_misaligned(lsu_funct3_in, lsu_addr_in[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM next state and outputs ----------------
    always_comb begin
        w_state_next      = r_state;
        w_capture         = 1'b0;
        w_timeout         = 1'b0;
        lsu_ready_out     = 1'b0;
        lsu_done_out      = 1'b0;
        lsu_err_out       = 1'b0;
        lsu_rdata_out     = 32'h0;
        lsu_rd_out        = 5'd0;
        data_addr_out     = 32'h0;
        data_wdata_out    = 32'h0;
        data_byte_en_out  = 4'b0000;
        data_read_en_out  = 1'b0;
        data_write_en_out = 1'b0;
        data_valid_out    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                lsu_ready_out = 1'b1;
                if (w_accept) begin
                    w_state_next = w_misaligned ? ST_RESP : ST_REQ;
                end
            end

            ST_REQ: begin
                data_valid_out    = 1'b1;
                data_addr_out     = {r_addr[31:2], 2'b00};
                data_byte_en_out  = lane_byte_en(r_funct3, r_addr[1:0]);
                data_wdata_out    = r_is_load ? 32'h0 : lane_wdata(r_funct3, r_wdata);
                data_read_en_out  = r_is_load;
                data_write_en_out = !r_is_load;
                if (data_ready_in) begin
                    if (!r_is_load) begin
                        w_state_next = ST_RESP;
                    end else if (data_rdata_valid_in) begin
                        // zero-latency responder: data arrives with acceptance
                        w_capture    = 1'b1;
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_WAIT_RD;
                    end
                end
            end

            ST_WAIT_RD: begin
                if (data_rdata_valid_in) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end

            ST_RESP: begin
                lsu_done_out  = 1'b1;
                lsu_err_out   = r_err;
                lsu_rd_out    = r_rd;
                lsu_rdata_out = (r_is_load && !r_err) ? w_load_data : 32'h0;
                w_state_next  = ST_IDLE;
            end

            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- Op capture and response datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_load    <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_rd         <= 5'd0;
            r_err        <= 1'b0;
            r_rdata_word <= 32'h0;
        end else begin
            if (w_accept) begin
                r_is_load    <= lsu_is_load_in;
                r_funct3     <= lsu_funct3_in;
                r_addr       <= lsu_addr_in;
                r_wdata      <= lsu_wdata_in;
                r_rd         <= lsu_rd_in;
                r_err        <= w_misaligned;
                r_rdata_word <= 32'h0;
            end
            if (w_capture) begin
                r_rdata_word <= data_rdata_in;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Held at zero through REQ so it starts from zero on entry to WAIT_RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT_RD) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    lsu_load_align u_load_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_word    (r_rdata_word),
        .o_data    (w_load_data)
    );

    assign dbg_state_out = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        lsu_valid_in = 1'b0;
  logic        lsu_is_load_in = 1'b0;
  logic        lsu_is_store_in = 1'b0;
  logic [2:0]  lsu_funct3_in = 3'b000;
  logic [31:0] lsu_addr_in = 32'h0;
  logic [31:0] lsu_wdata_in = 32'h0;
  logic [4:0]  lsu_rd_in = 5'd0;
  logic        lsu_ready_out;
  logic        lsu_done_out;
  logic [31:0] lsu_rdata_out;
  logic [4:0]  lsu_rd_out;
  logic        lsu_err_out;
  logic [31:0] data_addr_out;
  logic [31:0] data_wdata_out;
  logic [3:0]  data_byte_en_out;
  logic        data_read_en_out;
  logic        data_write_en_out;
  logic        data_valid_out;
  logic        data_ready_in = 1'b1;
  logic        data_rdata_valid_in = 1'b0;
  logic [31:0] data_rdata_in = 32'h0;
  lsu_state_t  dbg_state_out;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lsu_valid_in        (lsu_valid_in),
    .lsu_is_load_in      (lsu_is_load_in),
    .lsu_is_store_in     (lsu_is_store_in),
    .lsu_funct3_in       (lsu_funct3_in),
    .lsu_addr_in         (lsu_addr_in),
    .lsu_wdata_in        (lsu_wdata_in),
    .lsu_rd_in           (lsu_rd_in),
    .lsu_ready_out       (lsu_ready_out),
    .lsu_done_out        (lsu_done_out),
    .lsu_rdata_out       (lsu_rdata_out),
    .lsu_rd_out          (lsu_rd_out),
    .lsu_err_out         (lsu_err_out),
    .data_addr_out       (data_addr_out),
    .data_wdata_out      (data_wdata_out),
    .data_byte_en_out    (data_byte_en_out),
    .data_read_en_out    (data_read_en_out),
    .data_write_en_out   (data_write_en_out),
    .data_valid_out      (data_valid_out),
    .data_ready_in       (data_ready_in),
    .data_rdata_valid_in (data_rdata_valid_in),
    .data_rdata_in       (data_rdata_in),
    .dbg_state_out       (dbg_state_out)
  );

  // ---------------- scoreboard ----------------
  int assertions = 0;
  int failures   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op for one cycle; on return the op has been clocked in.
  task automatic issue(input logic is_load, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd);
    lsu_valid_in    = 1'b1;
    lsu_is_load_in  = is_load;
    lsu_is_store_in = !is_load;
    lsu_funct3_in   = f3;
    lsu_addr_in     = addr;
    lsu_wdata_in    = wdata;
    lsu_rd_in       = rd;
    tick();
    lsu_valid_in    = 1'b0;
    lsu_is_load_in  = 1'b0;
    lsu_is_store_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    tick();
    tick();
    check("rst_ready",  32'(lsu_ready_out), 32'd1);
    check("rst_done",   32'(lsu_done_out), 32'd0);
    check("rst_valid",  32'(data_valid_out), 32'd0);
    check("rst_be",     32'(data_byte_en_out), 32'd0);
    check("rst_err",    32'(lsu_err_out), 32'd0);
    check("rst_rdata",  lsu_rdata_out, 32'h0);
    rst = 1'b0;
    tick();

    // neither load nor store: ignored
    lsu_valid_in = 1'b1;
    tick();
    lsu_valid_in = 1'b0;
    check("nop_ready", 32'(lsu_ready_out), 32'd1);
    check("nop_valid", 32'(data_valid_out), 32'd0);

    // SW 0x100 DEADBEEF, ready immediate
    data_ready_in = 1'b1;
    issue(1'b0, F3_SW, 32'h100, 32'hDEADBEEF, 5'd0);
    check("sw_valid", 32'(data_valid_out), 32'd1);
    check("sw_addr",  data_addr_out, 32'h100);
    check("sw_be",    32'(data_byte_en_out), 32'hF);
    check("sw_we",    32'(data_write_en_out), 32'd1);
    check("sw_re",    32'(data_read_en_out), 32'd0);
    check("sw_wdata", data_wdata_out, 32'hDEADBEEF);
    check("sw_done_n1", 32'(lsu_done_out), 32'd0);
    check("sw_ready_busy", 32'(lsu_ready_out), 32'd0);
    tick();
    check("sw_done_n2", 32'(lsu_done_out), 32'd1);
    check("sw_err",     32'(lsu_err_out), 32'd0);
    check("sw_rdata",   lsu_rdata_out, 32'h0);
    tick();
    check("sw_done_clr", 32'(lsu_done_out), 32'd0);
    check("sw_idle",     32'(lsu_ready_out), 32'd1);

    // SB 0x103 A5
    issue(1'b0, F3_SB, 32'h103, 32'h000000A5, 5'd0);
    check("sb_addr",  data_addr_out, 32'h100);
    check("sb_be",    32'(data_byte_en_out), 32'h8);
    check("sb_wdata", data_wdata_out, 32'hA5A5A5A5);
    tick();
    check("sb_done",  32'(lsu_done_out), 32'd1);
    tick();

    // LB 0x102, word 0x12805634, rdata_valid 3 cycles after accept
    issue(1'b1, F3_LB, 32'h102, 32'h0, 5'd7);
    check("lb_be",  32'(data_byte_en_out), 32'h4);
    check("lb_re",  32'(data_read_en_out), 32'd1);
    check("lb_we",  32'(data_write_en_out), 32'd0);
    tick();
    check("lb_wait_state", 32'(dbg_state_out), 32'(ST_WAIT_RD));
    tick();
    check("lb_done_early", 32'(lsu_done_out), 32'd0);
    data_rdata_valid_in = 1'b1;
    data_rdata_in       = 32'h12805634;
    tick();
    data_rdata_valid_in = 1'b0;
    data_rdata_in       = 32'h0;
    check("lb_done",  32'(lsu_done_out), 32'd1);
    check("lb_rdata", lsu_rdata_out, 32'hFFFFFF80);
    check("lb_rd",    32'(lsu_rd_out), 32'd7);
    check("lb_err",   32'(lsu_err_out), 32'd0);
    tick();

    // LBU 0x102, zero-latency responder
    issue(1'b1, F3_LBU, 32'h102, 32'h0, 5'd9);
    data_rdata_valid_in = 1'b1;
    data_rdata_in       = 32'h12805634;
    tick();
    data_rdata_valid_in = 1'b0;
    data_rdata_in       = 32'h0;
    check("lbu_done",  32'(lsu_done_out), 32'd1);
    check("lbu_rdata", lsu_rdata_out, 32'h00000080);
    check("lbu_rd",    32'(lsu_rd_out), 32'd9);
    tick();

    // LH 0x102, ready held low 4 cycles
    data_ready_in = 1'b0;
    issue(1'b1, F3_LH, 32'h102, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      check("lh_hold_valid", 32'(data_valid_out), 32'd1);
      check("lh_hold_addr",  data_addr_out, 32'h100);
      check("lh_hold_be",    32'(data_byte_en_out), 32'hC);
      if (i < 3) tick();
    end
    data_ready_in = 1'b1;
    tick();
    check("lh_wait_done", 32'(lsu_done_out), 32'd0);
    data_rdata_valid_in = 1'b1;
    data_rdata_in       = 32'h12805634;
    tick();
    data_rdata_valid_in = 1'b0;
    check("lh_done",  32'(lsu_done_out), 32'd1);
    check("lh_rdata", lsu_rdata_out, 32'h00001280);
    tick();

    // LW timeout with TIMEOUT_CYCLES=16
    issue(1'b1, F3_LW, 32'h200, 32'h0, 5'd5);
    tick();
    for (int i = 1; i < 16; i++) begin
      check("to_waiting", 32'(lsu_done_out), 32'd0);
      tick();
    end
    check("to_last_wait", 32'(dbg_state_out), 32'(ST_WAIT_RD));
    tick();
    check("to_done",  32'(lsu_done_out), 32'd1);
    check("to_err",   32'(lsu_err_out), 32'd1);
    check("to_rdata", lsu_rdata_out, 32'h0);
    tick();
    data_rdata_valid_in = 1'b1;
    data_rdata_in       = 32'hFFFFFFFF;
    tick();
    data_rdata_valid_in = 1'b0;
    check("late_rv_done",  32'(lsu_done_out), 32'd0);
    check("late_rv_ready", 32'(lsu_ready_out), 32'd1);

    // LW 0x101 misaligned
    issue(1'b1, F3_LW, 32'h101, 32'h0, 5'd2);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_valid", 32'(data_valid_out), 32'd0);
    check("mis_done",  32'(lsu_done_out), 32'd1);
    check("mis_err",   32'(lsu_err_out), 32'd1);
    check("mis_rdata", lsu_rdata_out, 32'h0);
    tick();
`else
    check("mis_valid", 32'(data_valid_out), 32'd1);
    check("mis_addr",  data_addr_out, 32'h100);
    check("mis_be",    32'(data_byte_en_out), 32'hF);
    data_rdata_valid_in = 1'b1;
    data_rdata_in       = 32'hCAFEF00D;
    tick();
    data_rdata_valid_in = 1'b0;
    check("mis_done",  32'(lsu_done_out), 32'd1);
    check("mis_err",   32'(lsu_err_out), 32'd0);
    check("mis_rdata", lsu_rdata_out, 32'hCAFEF00D);
    tick();
`endif

    // reset asserted during REQ
    data_ready_in = 1'b0;
    issue(1'b0, F3_SW, 32'h300, 32'h11223344, 5'd0);
    check("mid_req_valid", 32'(data_valid_out), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(data_valid_out), 32'd0);
    check("mid_rst_ready", 32'(lsu_ready_out), 32'd1);
    check("mid_rst_done",  32'(lsu_done_out), 32'd0);
    tick();
    rst = 1'b0;
    data_ready_in = 1'b1;
    tick();
    check("post_rst_done",  32'(lsu_done_out), 32'd0);
    check("post_rst_ready", 32'(lsu_ready_out), 32'd1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
